// File: rtl/gray_counter_gen_if.sv
// Control and count bus for gray_counter_gen: the master drives the controls, the slave (counter) returns the count.
interface gray_counter_gen_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             enable;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             tc;
    logic             ovf;

    modport master (
        output enable, up, load, load_val,
        input  bin_out, gray_out, tc, ovf
    );

    modport slave (
        input  enable, up, load, load_val,
        output bin_out, gray_out, tc, ovf
    );
endinterface

// File: rtl/gray_counter_gen.sv
// Parametrised up/down binary counter with registered Gray output, wrap/saturate mode and overflow pulse.
// Optional macro GRAY_CNT_LOAD_GRAY_EN: load_val is Gray-coded and decoded to binary before loading.
module gray_counter_gen #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned RST_VAL  = 0,
    parameter int unsigned SATURATE = 0
) (
    input  logic            clk,
    input  logic            rst,
    gray_counter_gen_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] step_val;
    logic             tc_c;

`ifdef GRAY_CNT_LOAD_GRAY_EN
    // Prefix-XOR Gray decode: each binary bit is the parity of all Gray bits at or above it.
    always_comb begin
        load_bin = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            load_bin[i] = ^(bus.load_val >> i);
        end
    end
`else
    assign load_bin = bus.load_val;
`endif

    assign tc_c     = bus.up ? (bin_q == MAX_VAL) : (bin_q == '0);
    assign step_val = bus.up ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));

    // Next state: load beats enable; a step at terminal count wraps or holds and raises ovf.
    always_comb begin
        bin_d = bin_q;
        ovf_d = 1'b0;
        if (bus.load) begin
            bin_d = load_bin;
        end else if (bus.enable) begin
            bin_d = step_val;
            if (tc_c) begin
                ovf_d = 1'b1;
                if (SATURATE != 0) begin
                    bin_d = bin_q;
                end
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            ovf_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.bin_out  = bin_q;
    assign bus.gray_out = gray_q;
    assign bus.tc       = tc_c;
    assign bus.ovf      = ovf_q;
endmodule
